me_window_feeder: RTL and testbench
===================================

// Module: me_window_feeder
// PURPOSE
//  Source side of the basic-layer search input interface: fetches the 64x64 current CTU and the
//  reference search window from on-chip SRAMs and streams them to basic_layer_search as
//  current_64pixels rows (one 64-pixel row/word) and ref_input words (32 pixels/word), strip by strip,
//  with prepare strobes and column/row tags. Sits between the ME SRAM controller and basic_layer_search.
// PARAMETERS
//  PIX_W     8    bits per pixel
//  CUR_ROWS  64   current-block rows streamed per run
//  REF_ROWS  96   reference rows per column strip
//  N_STRIPS  4    column strips (search columns) per run
//  AW        10   SRAM address width
// PORTS
//  clk               in   1         clock
//  rst               in   1         synchronous reset, active-high
//  start             in   1         one-cycle run request; ignored when busy=1
//  hold              in   1         consumer stall: presented words not accepted this cycle
//  busy              out  1         run in progress
//  done              out  1         one-cycle pulse: run complete
//  cur_rd_en         out  1         current SRAM read strobe
//  cur_rd_addr       out  AW        current SRAM row address
//  cur_rd_data       in   64*PIX_W  current SRAM data, valid cycle after cur_rd_en
//  ref_rd_en         out  1         reference SRAM read strobe
//  ref_rd_addr       out  AW        reference SRAM row address
//  ref_rd_data       in   32*PIX_W  reference SRAM data, valid cycle after ref_rd_en
//  current_64pixels  out  64*PIX_W  current row word
//  cur_valid         out  1         current_64pixels valid
//  pe_begin_prepare  out  1         high with current row 0 only
//  ref_input         out  32*PIX_W  reference row word
//  ref_valid         out  1         ref_input valid
//  ref_begin_prepare out  1         high with row 0 of each strip only
//  search_column_count out clog2(N_STRIPS) strip index of ref_input word
//  search_row_count  out  clog2(REF_ROWS)  row index of ref_input word
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; skid FIFOs empty; in-flight flags cleared (data returning the
//    cycle after rst is discarded). rst wins over start in the same cycle.
//  - FSM: IDLE -start-> CUR (issue CUR_ROWS reads, addr 0..CUR_ROWS-1) -> CUR_DRAIN (wait until last
//    cur word accepted) -> REF (issue N_STRIPS*REF_ROWS reads, addr = strip*REF_ROWS+row, strips
//    back-to-back, no bubble) -> REF_DRAIN (wait last ref word accepted) -> IDLE with done=1, busy=0
//    in that same cycle. busy=1 in every non-IDLE state.
//  - Each stream has a 3-entry skid FIFO; data+tags (prepare bit, column, row) pushed the cycle after
//    rd_en. Read issued only if occupancy + in-flight < 3 and rows remain; full rate (1 word/cycle)
//    when hold=0. hold does not gate issue; credit rule alone prevents overflow.
//  - valid = FIFO non-empty; pop when valid && !hold. While held, word and tags stay stable.
//  - Latency: start in cycle 0 -> cur_rd_en cycle 1 -> cur_valid first in cycle 3.
//  - Last cur accepted cycle c -> first ref_rd_en cycle c+1 -> ref_valid first c+3.
//  - Counters wrap only at their limits: row REF_ROWS-1 -> 0 with column +1; no overrun past last strip.
//  - Reset mid-run: next cycle IDLE, valids 0, no done pulse.
// STRUCTURE
//  - Package me_pkg: PIX_W, CUR_PIX=64, REF_PIX=32, fsm_state_t enum (IDLE,CUR,CUR_DRAIN,REF,REF_DRAIN).
//  - Sub-module me_skid_fifo #(W, DEPTH=3): sync FIFO, push/pop/occupancy, sync rst flush;
//    instantiated twice (cur: 64*PIX_W+1 bits; ref: 32*PIX_W+1+tag bits).
// TESTING (override CUR_ROWS=4, REF_ROWS=6, N_STRIPS=2; SRAM models return data = address)
//  1 rst for 2 cycles -> every output 0, busy=0; start held during rst -> no reads issued.
//  2 start cycle 0, hold=0 -> cur_valid cycles 3..6 rows 0..3, pe_begin_prepare only cycle 3;
//    ref_valid 9..20 addr 0..11, ref_begin_prepare at addr 0 and 6, column 0/1, rows 0..5; done cycle 21.
//  3 hold=1 cycles 12..14 -> ref word addr 3 stable 12..15, no loss/dup, FIFO occupancy <=3, done cycle 24.
//  4 start pulses at cycles 5 and 15 of a run -> ignored; exactly one done, word counts unchanged.
//  5 rst at cycle 11 -> cycle 12 IDLE, valids 0, no done; SRAM data returned cycle 12 never presented;
//    new start cycle 14 -> run identical to scenario 2 shifted by 14.
//  6 hold=1 on last ref word (addr 11) for 4 cycles -> done delayed to 1 cycle after its acceptance.

Source files
------------

// File: rtl/me_window_feeder_pkg.sv
// me_pkg: shared constants and types for the motion-estimation window feeder.
//   PIX_W       default bits per pixel
//   CUR_PIX     pixels per current-block row word
//   REF_PIX     pixels per reference row word
//   FIFO_DEPTH  entries per skid FIFO; also the read-credit limit
//   fsm_state_t sequencing states of the feeder
package me_pkg;
    localparam int PIX_W      = 8;
    localparam int CUR_PIX    = 64;
    localparam int REF_PIX    = 32;
    localparam int FIFO_DEPTH = 3;

    typedef enum logic [2:0] {
        IDLE,
        CUR,
        CUR_DRAIN,
        REF,
        REF_DRAIN
    } fsm_state_t;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/me_window_feeder_if.sv
// me_window_feeder_if: stream from the window feeder into basic_layer_search.
//   current_64pixels / cur_valid / pe_begin_prepare        current-block rows
//   ref_input / ref_valid / ref_begin_prepare               reference rows
//   search_column_count / search_row_count                  tags of ref_input
//   hold                                                    consumer stall
// master = feeder side, slave = consumer side.
interface me_window_feeder_if #(
    parameter int PIX_W = 8,
    parameter int COL_W = 2,
    parameter int ROW_W = 7
);
    logic [me_pkg::CUR_PIX*PIX_W-1:0] current_64pixels;
    logic                             cur_valid;
    logic                             pe_begin_prepare;
    logic [me_pkg::REF_PIX*PIX_W-1:0] ref_input;
    logic                             ref_valid;
    logic                             ref_begin_prepare;
    logic [COL_W-1:0]                 search_column_count;
    logic [ROW_W-1:0]                 search_row_count;
    logic                             hold;

    modport master (
        output current_64pixels, cur_valid, pe_begin_prepare,
        output ref_input, ref_valid, ref_begin_prepare,
        output search_column_count, search_row_count,
        input  hold
    );

    modport slave (
        input  current_64pixels, cur_valid, pe_begin_prepare,
        input  ref_input, ref_valid, ref_begin_prepare,
        input  search_column_count, search_row_count,
        output hold
    );
endinterface

// File: rtl/me_skid_fifo.sv
// me_skid_fifo: small synchronous FIFO absorbing SRAM read latency under consumer stall.
//   clk, rst    clock, synchronous active-high flush
//   push, din   write one entry
//   pop         remove head entry (ignored when empty)
//   dout        head entry
//   count       current occupancy
//   empty       occupancy is zero
module me_skid_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 3,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             empty
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/me_window_feeder.sv
// me_window_feeder: fetches the current CTU and the reference search window from SRAM
// and streams them to basic_layer_search, current block first, then reference strips.
//   clk, rst                 clock, synchronous active-high reset
//   start / busy / done      run request, run in progress, one-cycle completion pulse
//   cur_rd_*                 current SRAM read port (data one cycle after enable)
//   ref_rd_*                 reference SRAM read port (data one cycle after enable)
//   strm                     consumer stream (words, valids, prepare strobes, tags, hold)
//
// state     | meaning
// IDLE      | waiting for start
// CUR       | issuing current-block row reads
// CUR_DRAIN | all current reads issued, waiting for last row to be accepted
// REF       | issuing reference reads, strips back-to-back
// REF_DRAIN | all reference reads issued, waiting for last word to be accepted
module me_window_feeder import me_pkg::*; #(
    parameter int PIX_W    = me_pkg::PIX_W,
    parameter int CUR_ROWS = 64,
    parameter int REF_ROWS = 96,
    parameter int N_STRIPS = 4,
    parameter int AW       = 10,
    localparam int COL_W   = clog2_min1(N_STRIPS),
    localparam int ROW_W   = clog2_min1(REF_ROWS),
    localparam int CIDX_W  = clog2_min1(CUR_ROWS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       cur_rd_en,
    output logic [AW-1:0]              cur_rd_addr,
    input  logic [CUR_PIX*PIX_W-1:0]   cur_rd_data,
    output logic                       ref_rd_en,
    output logic [AW-1:0]              ref_rd_addr,
    input  logic [REF_PIX*PIX_W-1:0]   ref_rd_data,
    me_window_feeder_if.master         strm
);
    localparam int CUR_W     = CUR_PIX * PIX_W;
    localparam int REF_W     = REF_PIX * PIX_W;
    localparam int REF_TOTAL = N_STRIPS * REF_ROWS;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int CUR_FW    = CUR_W + 1;
    localparam int REF_FW    = REF_W + 1 + COL_W + ROW_W;

    fsm_state_t state_q, state_d;
    logic       done_d;

    logic [CIDX_W-1:0] cur_row_q;
    logic [ROW_W-1:0]  ref_row_q;
    logic [COL_W-1:0]  ref_col_q;
    logic [AW-1:0]     ref_addr_q;

    // Tags travel alongside the read so they land in the FIFO with the returned data.
    logic              cur_infl_q, cur_infl_first_q;
    logic              ref_infl_q, ref_infl_first_q;
    logic [COL_W-1:0]  ref_infl_col_q;
    logic [ROW_W-1:0]  ref_infl_row_q;

    logic [CNT_W-1:0]  cur_cnt, ref_cnt;
    logic              cur_empty, ref_empty;
    logic [CUR_FW-1:0] cur_dout;
    logic [REF_FW-1:0] ref_dout;

    logic cur_credit, ref_credit;
    logic cur_issue, ref_issue, cur_last_issue, ref_last_issue;
    logic cur_pop, ref_pop, cur_last_accept, ref_last_accept;

    // A read is allowed only if its word is guaranteed a FIFO slot on return,
    // so hold never needs to gate issue.
    assign cur_credit = ({1'b0, cur_cnt} + (CNT_W+1)'(cur_infl_q)) < (CNT_W+1)'(FIFO_DEPTH);
    assign ref_credit = ({1'b0, ref_cnt} + (CNT_W+1)'(ref_infl_q)) < (CNT_W+1)'(FIFO_DEPTH);

    assign cur_issue      = (state_q == CUR) && cur_credit;
    assign ref_issue      = (state_q == REF) && ref_credit;
    assign cur_last_issue = cur_issue && (cur_row_q == CIDX_W'(CUR_ROWS - 1));
    assign ref_last_issue = ref_issue && (ref_addr_q == AW'(REF_TOTAL - 1));

    assign cur_pop = !cur_empty && !strm.hold;
    assign ref_pop = !ref_empty && !strm.hold;
    assign cur_last_accept = (state_q == CUR_DRAIN) && cur_pop && !cur_infl_q && (cur_cnt == CNT_W'(1));
    assign ref_last_accept = (state_q == REF_DRAIN) && ref_pop && !ref_infl_q && (ref_cnt == CNT_W'(1));

    assign cur_rd_en   = cur_issue;
    assign cur_rd_addr = AW'(cur_row_q);
    assign ref_rd_en   = ref_issue;
    assign ref_rd_addr = ref_addr_q;
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE:      if (start) state_d = CUR;
            CUR:       if (cur_last_issue) state_d = CUR_DRAIN;
            CUR_DRAIN: if (cur_last_accept) state_d = REF;
            REF:       if (ref_last_issue) state_d = REF_DRAIN;
            REF_DRAIN: begin
                if (ref_last_accept) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            done             <= 1'b0;
            cur_row_q        <= '0;
            ref_row_q        <= '0;
            ref_col_q        <= '0;
            ref_addr_q       <= '0;
            cur_infl_q       <= 1'b0;
            cur_infl_first_q <= 1'b0;
            ref_infl_q       <= 1'b0;
            ref_infl_first_q <= 1'b0;
            ref_infl_col_q   <= '0;
            ref_infl_row_q   <= '0;
        end else begin
            state_q          <= state_d;
            done             <= done_d;
            cur_infl_q       <= cur_issue;
            cur_infl_first_q <= cur_issue && (cur_row_q == '0);
            ref_infl_q       <= ref_issue;
            ref_infl_first_q <= ref_issue && (ref_row_q == '0);
            ref_infl_col_q   <= ref_col_q;
            ref_infl_row_q   <= ref_row_q;
            if (state_q == IDLE) begin
                cur_row_q  <= '0;
                ref_row_q  <= '0;
                ref_col_q  <= '0;
                ref_addr_q <= '0;
            end else begin
                if (cur_issue && !cur_last_issue) begin
                    cur_row_q <= cur_row_q + CIDX_W'(1);
                end
                // Counters freeze on the final read so the column never steps past the last strip.
                if (ref_issue && !ref_last_issue) begin
                    ref_addr_q <= ref_addr_q + AW'(1);
                    if (ref_row_q == ROW_W'(REF_ROWS - 1)) begin
                        ref_row_q <= '0;
                        ref_col_q <= ref_col_q + COL_W'(1);
                    end else begin
                        ref_row_q <= ref_row_q + ROW_W'(1);
                    end
                end
            end
        end
    end

    me_skid_fifo #(.W(CUR_FW), .DEPTH(FIFO_DEPTH)) u_cur_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cur_infl_q),
        .din   ({cur_infl_first_q, cur_rd_data}),
        .pop   (cur_pop),
        .dout  (cur_dout),
        .count (cur_cnt),
        .empty (cur_empty)
    );

    me_skid_fifo #(.W(REF_FW), .DEPTH(FIFO_DEPTH)) u_ref_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ref_infl_q),
        .din   ({ref_infl_first_q, ref_infl_col_q, ref_infl_row_q, ref_rd_data}),
        .pop   (ref_pop),
        .dout  (ref_dout),
        .count (ref_cnt),
        .empty (ref_empty)
    );

    assign strm.cur_valid           = !cur_empty;
    assign strm.current_64pixels    = cur_dout[CUR_W-1:0];
    assign strm.pe_begin_prepare    = !cur_empty && cur_dout[CUR_W];
    assign strm.ref_valid           = !ref_empty;
    assign strm.ref_input           = ref_dout[REF_W-1:0];
    assign strm.search_row_count    = ref_dout[REF_W +: ROW_W];
    assign strm.search_column_count = ref_dout[REF_W+ROW_W +: COL_W];
    assign strm.ref_begin_prepare   = !ref_empty && ref_dout[REF_W+ROW_W+COL_W];
endmodule

// File: tb/tb_me_window_feeder.sv
module tb_me_window_feeder;
    localparam int PIX_W    = 8;
    localparam int CUR_ROWS = 4;
    localparam int REF_ROWS = 6;
    localparam int N_STRIPS = 2;
    localparam int AW       = 10;
    localparam int CUR_W    = 64 * PIX_W;
    localparam int REF_W    = 32 * PIX_W;
    localparam int COL_W    = 1;
    localparam int ROW_W    = 3;
    localparam int MAXC     = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy, done;
    logic            cur_rd_en, ref_rd_en;
    logic [AW-1:0]   cur_rd_addr, ref_rd_addr;
    logic [CUR_W-1:0] cur_rd_data;
    logic [REF_W-1:0] ref_rd_data;

    me_window_feeder_if #(.PIX_W(PIX_W), .COL_W(COL_W), .ROW_W(ROW_W)) strm ();

    me_window_feeder #(
        .PIX_W(PIX_W), .CUR_ROWS(CUR_ROWS), .REF_ROWS(REF_ROWS), .N_STRIPS(N_STRIPS), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .cur_rd_en(cur_rd_en), .cur_rd_addr(cur_rd_addr), .cur_rd_data(cur_rd_data),
        .ref_rd_en(ref_rd_en), .ref_rd_addr(ref_rd_addr), .ref_rd_data(ref_rd_data),
        .strm(strm)
    );

    always #5 clk = ~clk;

    // Pixel pattern is a function of the SRAM address, so each word identifies its row.
    function automatic logic [CUR_W-1:0] cur_pat(input int a);
        logic [CUR_W-1:0] w;
        for (int p = 0; p < 64; p++) w[p*PIX_W +: PIX_W] = PIX_W'(a * 7 + p);
        return w;
    endfunction

    function automatic logic [REF_W-1:0] ref_pat(input int a);
        logic [REF_W-1:0] w;
        for (int p = 0; p < 32; p++) w[p*PIX_W +: PIX_W] = PIX_W'(a * 13 + 3 * p + 1);
        return w;
    endfunction

    always @(posedge clk) begin
        if (cur_rd_en) cur_rd_data <= cur_pat(int'(cur_rd_addr));
        if (ref_rd_en) ref_rd_data <= ref_pat(int'(ref_rd_addr));
    end

    int checks = 0;
    int failures = 0;
    string g_tag = "";

    int l_cv[MAXC], l_cp[MAXC], l_rv[MAXC], l_rp[MAXC], l_col[MAXC], l_row[MAXC];
    int l_hold[MAXC], l_cre[MAXC], l_rre[MAXC], l_cra[MAXC], l_rra[MAXC];
    int l_done[MAXC], l_busy[MAXC];
    logic [CUR_W-1:0] l_cd[MAXC];
    logic [REF_W-1:0] l_rd[MAXC];
    int nlog = 0;
    int done_t = -1;

    typedef struct {
        int hf;
        int hl;
        int xs;
        int exp_done;
        int exp_ref_first;
    } vec_t;
    vec_t vecs[5];

    task automatic check_eq(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s %s: got %0d expected %0d", g_tag, nm, act, exp);
        end
    endtask

    task automatic check_vec(input string nm, input logic [CUR_W-1:0] act, input logic [CUR_W-1:0] exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s %s: got ..%h expected ..%h", g_tag, nm, act[31:0], exp[31:0]);
        end
    endtask

    task automatic sample(input int t);
        l_cv[t]   = int'(strm.cur_valid);
        l_cp[t]   = int'(strm.pe_begin_prepare);
        l_cd[t]   = strm.current_64pixels;
        l_rv[t]   = int'(strm.ref_valid);
        l_rp[t]   = int'(strm.ref_begin_prepare);
        l_rd[t]   = strm.ref_input;
        l_col[t]  = int'(strm.search_column_count);
        l_row[t]  = int'(strm.search_row_count);
        l_hold[t] = int'(strm.hold);
        l_cre[t]  = int'(cur_rd_en);
        l_rre[t]  = int'(ref_rd_en);
        l_cra[t]  = int'(cur_rd_addr);
        l_rra[t]  = int'(ref_rd_addr);
        l_done[t] = int'(done);
        l_busy[t] = int'(busy);
        if (done && done_t < 0) done_t = t;
        nlog = t + 1;
    endtask

    task automatic check_idle(input int t);
        g_tag = $sformatf("reset_t%0d", t);
        check_eq("busy", int'(busy), 0);
        check_eq("done", int'(done), 0);
        check_eq("cur_rd_en", int'(cur_rd_en), 0);
        check_eq("ref_rd_en", int'(ref_rd_en), 0);
        check_eq("cur_rd_addr", int'(cur_rd_addr), 0);
        check_eq("ref_rd_addr", int'(ref_rd_addr), 0);
        check_eq("cur_valid", int'(strm.cur_valid), 0);
        check_eq("ref_valid", int'(strm.ref_valid), 0);
        check_eq("pe_begin_prepare", int'(strm.pe_begin_prepare), 0);
        check_eq("ref_begin_prepare", int'(strm.ref_begin_prepare), 0);
        check_eq("column", int'(strm.search_column_count), 0);
        check_eq("row", int'(strm.search_row_count), 0);
        check_vec("current_64pixels", strm.current_64pixels, '0);
        check_vec("ref_input", CUR_W'(strm.ref_input), '0);
    endtask

    // start at relative cycle 0; run until two cycles past done or the budget expires
    task automatic run_once(input int hf, input int hl, input int xs, input int rnd);
        done_t = -1;
        nlog = 0;
        for (int t = 0; t < MAXC; t++) begin
            start = (t == 0) || (xs != 0 && (t == 5 || t == 15));
            if (rnd != 0) strm.hold = ($urandom_range(0, 2) == 0);
            else          strm.hold = (t >= hf && t < hf + hl);
            #4;
            sample(t);
            @(posedge clk);
            #1;
            if (done_t >= 0 && t >= done_t + 2) break;
        end
        start = 1'b0;
        strm.hold = 1'b0;
    endtask

    // Reference model: streams carry rows in order with derived tags, each stream is
    // gapless once it starts, and the cycle relations between phases are fixed.
    task automatic check_run(input int exp_done, input int exp_ref_first);
        int ncur = 0, nref = 0, ncra = 0, nrra = 0;
        int cfirst = -1, clast = -1, rfirst = -1, rlast = -1;
        int crefirst = -1, rrefirst = -1, ndone = 0, dt = -1;
        int gaps = 0, both = 0, bad_busy = 0, stable;
        for (int t = 0; t < nlog; t++) begin
            if (l_cv[t] != 0 && cfirst < 0) cfirst = t;
            if (l_rv[t] != 0 && rfirst < 0) rfirst = t;
            if (l_cv[t] != 0 && l_rv[t] != 0) both++;
            if (l_cv[t] != 0 && l_hold[t] == 0) begin
                check_vec($sformatf("cur_word%0d", ncur), l_cd[t], cur_pat(ncur));
                check_eq($sformatf("cur_prep%0d", ncur), l_cp[t], int'(ncur == 0));
                ncur++;
                clast = t;
            end
            if (l_rv[t] != 0 && l_hold[t] == 0) begin
                check_vec($sformatf("ref_word%0d", nref), CUR_W'(l_rd[t]), CUR_W'(ref_pat(nref)));
                check_eq($sformatf("ref_prep%0d", nref), l_rp[t], int'(nref % REF_ROWS == 0));
                check_eq($sformatf("ref_col%0d", nref), l_col[t], nref / REF_ROWS);
                check_eq($sformatf("ref_row%0d", nref), l_row[t], nref % REF_ROWS);
                nref++;
                rlast = t;
            end
            if (l_cv[t] != 0 && l_hold[t] != 0 && t + 1 < nlog) begin
                stable = int'(l_cv[t+1] != 0 && l_cd[t+1] == l_cd[t] && l_cp[t+1] == l_cp[t]);
                check_eq($sformatf("cur_hold_stable_t%0d", t), stable, 1);
            end
            if (l_rv[t] != 0 && l_hold[t] != 0 && t + 1 < nlog) begin
                stable = int'(l_rv[t+1] != 0 && l_rd[t+1] == l_rd[t] && l_rp[t+1] == l_rp[t]
                              && l_col[t+1] == l_col[t] && l_row[t+1] == l_row[t]);
                check_eq($sformatf("ref_hold_stable_t%0d", t), stable, 1);
            end
            if (l_cre[t] != 0) begin
                if (crefirst < 0) crefirst = t;
                check_eq($sformatf("cur_rd_addr%0d", ncra), l_cra[t], ncra);
                ncra++;
            end
            if (l_rre[t] != 0) begin
                if (rrefirst < 0) rrefirst = t;
                check_eq($sformatf("ref_rd_addr%0d", nrra), l_rra[t], nrra);
                nrra++;
            end
            if (l_done[t] != 0) begin
                ndone++;
                dt = t;
            end
        end
        if (cfirst >= 0) for (int t = cfirst; t <= clast; t++) if (l_cv[t] == 0) gaps++;
        if (rfirst >= 0) for (int t = rfirst; t <= rlast; t++) if (l_rv[t] == 0) gaps++;
        if (l_busy[0] != 0) bad_busy++;
        for (int t = 1; t < nlog; t++) begin
            if (dt >= 0 && t >= dt) begin
                if (l_busy[t] != 0) bad_busy++;
            end else if (l_busy[t] == 0) begin
                bad_busy++;
            end
        end
        check_eq("cur_words", ncur, CUR_ROWS);
        check_eq("ref_words", nref, N_STRIPS * REF_ROWS);
        check_eq("cur_reads", ncra, CUR_ROWS);
        check_eq("ref_reads", nrra, N_STRIPS * REF_ROWS);
        check_eq("cur_rd_first", crefirst, 1);
        check_eq("cur_valid_first", cfirst, 3);
        check_eq("ref_rd_first", rrefirst, clast + 1);
        check_eq("ref_valid_first", rfirst, clast + 3);
        check_eq("stream_gaps", gaps, 0);
        check_eq("both_valid", both, 0);
        check_eq("done_count", ndone, 1);
        check_eq("done_after_last", dt, rlast + 1);
        check_eq("busy_profile", bad_busy, 0);
        if (exp_ref_first >= 0) check_eq("ref_valid_first_abs", rfirst, exp_ref_first);
        if (exp_done >= 0) check_eq("done_cycle_abs", dt, exp_done);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        strm.hold = 1'b0;

        // reset with start held high: rst wins, nothing issued afterwards
        for (int t = 0; t < 5; t++) begin
            rst = (t < 2);
            start = (t < 2);
            #4;
            if (t >= 1) check_idle(t);
            @(posedge clk);
            #1;
        end
        start = 1'b0;

        vecs[0] = '{hf: 0,  hl: 0, xs: 0, exp_done: 21, exp_ref_first: 9};
        vecs[1] = '{hf: 12, hl: 3, xs: 0, exp_done: 24, exp_ref_first: 9};
        vecs[2] = '{hf: 20, hl: 4, xs: 0, exp_done: 25, exp_ref_first: 9};
        vecs[3] = '{hf: 4,  hl: 2, xs: 0, exp_done: 23, exp_ref_first: 11};
        vecs[4] = '{hf: 0,  hl: 0, xs: 1, exp_done: 21, exp_ref_first: 9};
        for (int i = 0; i < 5; i++) begin
            run_once(vecs[i].hf, vecs[i].hl, vecs[i].xs, 0);
            g_tag = $sformatf("vec%0d", i);
            check_run(vecs[i].exp_done, vecs[i].exp_ref_first);
        end

        // reset in the middle of the reference phase
        done_t = -1;
        nlog = 0;
        for (int t = 0; t < 14; t++) begin
            start = (t == 0);
            rst = (t == 11);
            strm.hold = 1'b0;
            #4;
            sample(t);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        start = 1'b0;
        g_tag = "midrst";
        check_eq("ref_valid_before_rst", l_rv[11], 1);
        for (int t = 12; t < 14; t++) begin
            check_eq($sformatf("busy_t%0d", t), l_busy[t], 0);
            check_eq($sformatf("cur_valid_t%0d", t), l_cv[t], 0);
            check_eq($sformatf("ref_valid_t%0d", t), l_rv[t], 0);
            check_eq($sformatf("ref_rd_en_t%0d", t), l_rre[t], 0);
        end
        check_eq("no_done", done_t, -1);
        run_once(0, 0, 0, 0);
        g_tag = "after_rst";
        check_run(21, 9);

        for (int i = 0; i < 8; i++) begin
            run_once(0, 0, 0, 1);
            g_tag = $sformatf("rand%0d", i);
            check_run(-1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
